// File: rtl/adder_share_arbiter_if.sv
// Request/response bundle for adder_share_arbiter: NUM_REQ requesters share one
// valid/ready result channel. master = clients/consumer side, slave = arbiter.
interface adder_share_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 3
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_operand;
    logic [NUM_REQ-1:0]       req_sel;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [WIDTH-1:0]         rsp_data;
    logic [ID_W-1:0]          rsp_id;
    logic                     busy;

    modport master (
        output req_valid, req_operand, req_sel, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id, busy
    );

    modport slave (
        input  req_valid, req_operand, req_sel, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id, busy
    );
endinterface

// File: rtl/adder_share_arbiter.sv
// Shares one registered "add constant" unit among NUM_REQ requesters, one op per cycle.
// Define ADD_ARB_PRIORITY_EN for fixed priority (lowest index wins) instead of round-robin.
module adder_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 3,
    parameter int ADD_A   = 7,
    parameter int ADD_B   = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    adder_share_arbiter_if.slave bus
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [WIDTH-1:0] CONST_A = WIDTH'(ADD_A);
    localparam logic [WIDTH-1:0] CONST_B = WIDTH'(ADD_B);

    typedef enum logic {IDLE, FULL} state_t;

    state_t           state, state_next;
    logic             grant_valid;
    logic [ID_W-1:0]  grant_idx;
    logic             slot_free;
    logic             accept;
    logic [WIDTH-1:0] operand [NUM_REQ];
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] rsp_data_q;
    logic [ID_W-1:0]  rsp_id_q;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign operand[i] = bus.req_operand[i*WIDTH +: WIDTH];
    end

`ifdef ADD_ARB_PRIORITY_EN
    // Scan from the top down so the lowest valid index is the last writer.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req_valid[ID_W'(k)]) begin
                grant_valid = 1'b1;
                grant_idx   = ID_W'(k);
            end
        end
    end
`else
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] idx;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!grant_valid && bus.req_valid[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = idx;
            end
        end
    end

    // NOTE: reset is synchronous, so it lives inside the clocked branch, and state uses <= only.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end
`endif

    assign slot_free = (state == IDLE) | bus.rsp_ready;
    assign accept    = reset_n & grant_valid & slot_free;
    assign result    = operand[grant_idx] + (bus.req_sel[grant_idx] ? CONST_B : CONST_A);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = FULL;
            FULL: if (!accept && bus.rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        if (accept) begin
            bus.req_ready[grant_idx] = 1'b1;
        end
        bus.rsp_valid = (state == FULL);
        bus.busy      = (state == FULL) | (|bus.req_valid);
    end

    // Result register reloads only on acceptance, so it holds steady during a stall.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rsp_data_q <= '0;
            rsp_id_q   <= '0;
        end else if (accept) begin
            rsp_data_q <= result;
            rsp_id_q   <= grant_idx;
        end
    end

    assign bus.rsp_data = rsp_data_q;
    assign bus.rsp_id   = rsp_id_q;
endmodule
